// File: rtl/qdot_pkg.sv
// qdot_pkg: shared types and widths for the int8-weight x Q16.16 dot-product job controller.
package qdot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int Q_FRAC    = 16;
  localparam int X_W       = 32;
  localparam int W_W       = 8;
  localparam int PROD_W    = 40;
  localparam int DRAIN_CYC = 2;

endpackage

// File: rtl/qdot_if.sv
// qdot_if: job request, beat stream and result handshake bundle for qdot_sched.
// sat_o is present only when QDOT_SAT_EN is defined.
interface qdot_if #(parameter int LEN_W = 8);

  logic              start_i;
  logic [LEN_W-1:0]  len_i;
  logic [4:0]        shift_i;
  logic              busy_o;
  logic              x_valid_i;
  logic signed [31:0] vector_x_i;
  logic signed [7:0]  quant_w_i;
  logic              x_ready_o;
  logic              dout_valid_o;
  logic [31:0]       dout_o;
  logic              dout_ready_i;
  logic              done_o;
`ifdef QDOT_SAT_EN
  logic              sat_o;
`endif

`ifdef QDOT_SAT_EN
  modport master (
    output start_i, len_i, shift_i, x_valid_i, vector_x_i, quant_w_i, dout_ready_i,
    input  busy_o, x_ready_o, dout_valid_o, dout_o, done_o, sat_o
  );
  modport slave (
    input  start_i, len_i, shift_i, x_valid_i, vector_x_i, quant_w_i, dout_ready_i,
    output busy_o, x_ready_o, dout_valid_o, dout_o, done_o, sat_o
  );
`else
  modport master (
    output start_i, len_i, shift_i, x_valid_i, vector_x_i, quant_w_i, dout_ready_i,
    input  busy_o, x_ready_o, dout_valid_o, dout_o, done_o
  );
  modport slave (
    input  start_i, len_i, shift_i, x_valid_i, vector_x_i, quant_w_i, dout_ready_i,
    output busy_o, x_ready_o, dout_valid_o, dout_o, done_o
  );
`endif

endinterface

// File: rtl/qdot_mac.sv
// qdot_mac: two-stage MAC; stage1 registers the 40-bit signed product, stage2 accumulates it.
// A valid bit travels with the product so stalled cycles leave the accumulator untouched.
module qdot_mac
  import qdot_pkg::*;
#(
  parameter int ACC_W = 48
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    i_en,
  input  logic                    i_clr,
  input  logic signed [X_W-1:0]   i_x,
  input  logic signed [W_W-1:0]   i_w,
  output logic signed [ACC_W-1:0] o_acc
);

  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] r_prod;
  logic                     r_prodVld;
  logic signed [ACC_W-1:0]  r_acc;

  assign w_prod = $signed({{(PROD_W-X_W){i_x[X_W-1]}}, i_x}) *
                  $signed({{(PROD_W-W_W){i_w[W_W-1]}}, i_w});

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_prod    <= '0;
      r_prodVld <= 1'b0;
      r_acc     <= '0;
    end else if (i_clr) begin
      r_prod    <= '0;
      r_prodVld <= 1'b0;
      r_acc     <= '0;
    end else begin
      r_prodVld <= i_en;
      if (i_en) begin
        r_prod <= w_prod;
      end
      if (r_prodVld) begin
        r_acc <= r_acc + {{(ACC_W-PROD_W){r_prod[PROD_W-1]}}, r_prod};
      end
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/qdot_sched.sv
// qdot_sched: job FSM around qdot_mac; rescales the accumulator and presents one Q16.16 result.
// Define QDOT_SAT_EN to saturate the narrowed result and expose sat_o; otherwise it wraps.
module qdot_sched
  import qdot_pkg::*;
#(
  parameter int LEN_W = 8,
  parameter int ACC_W = 48
) (
  input  logic clk_i,
  input  logic rst_i,
  qdot_if.slave bus
);

  state_t                  r_state;
  logic [LEN_W-1:0]        r_len;
  logic [LEN_W-1:0]        r_cnt;
  logic [4:0]              r_shift;
  logic [1:0]              r_drainCnt;
  logic [31:0]             r_dout;
  logic                    r_doutValid;
  logic                    w_beat;
  logic                    w_take;
  logic                    w_clr;
  logic signed [ACC_W-1:0] w_acc;
  logic [31:0]             w_narrow;

  assign w_beat = (r_state == RUN) & bus.x_valid_i;
  assign w_take = r_doutValid & bus.dout_ready_i;
  assign w_clr  = (r_state == IDLE) & bus.start_i;

  qdot_mac #(.ACC_W(ACC_W)) u_mac (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .i_en  (w_beat),
    .i_clr (w_clr),
    .i_x   (bus.vector_x_i),
    .i_w   (bus.quant_w_i),
    .o_acc (w_acc)
  );

`ifdef QDOT_SAT_EN
  logic signed [ACC_W-1:0] w_shifted;
  logic                    w_fits;
  logic                    w_clip;
  logic                    r_sat;

  // Result fits in 32 bits only when every bit above bit 31 matches the sign.
  assign w_shifted = w_acc >>> r_shift;
  assign w_fits    = (&w_shifted[ACC_W-1:31]) | ~(|w_shifted[ACC_W-1:31]);
  assign w_clip    = ~w_fits;
  assign w_narrow  = w_fits ? w_shifted[31:0] :
                     (w_shifted[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF);
  assign bus.sat_o = r_sat;
`else
  assign w_narrow  = 32'(w_acc >>> r_shift);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_drainCnt  <= '0;
      r_dout      <= '0;
      r_doutValid <= 1'b0;
`ifdef QDOT_SAT_EN
      r_sat       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start_i) begin
            r_len      <= bus.len_i;
            r_shift    <= bus.shift_i;
            r_cnt      <= '0;
            r_drainCnt <= '0;
            r_state    <= (bus.len_i == '0) ? DRAIN : RUN;
          end
        end
        RUN: begin
          if (bus.x_valid_i) begin
            r_cnt <= r_cnt + LEN_W'(1);
            if (r_cnt == r_len - LEN_W'(1)) begin
              r_state <= DRAIN;
            end
          end
        end
        // Two cycles let the last product pass both MAC stages before narrowing.
        DRAIN: begin
          if (r_drainCnt == 2'(DRAIN_CYC - 1)) begin
            r_drainCnt  <= '0;
            r_dout      <= w_narrow;
            r_doutValid <= 1'b1;
`ifdef QDOT_SAT_EN
            r_sat       <= w_clip;
`endif
            r_state     <= OUT;
          end else begin
            r_drainCnt <= r_drainCnt + 2'd1;
          end
        end
        OUT: begin
          if (w_take) begin
            r_doutValid <= 1'b0;
`ifdef QDOT_SAT_EN
            r_sat       <= 1'b0;
`endif
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o       = (r_state != IDLE);
  assign bus.x_ready_o    = (r_state == RUN);
  assign bus.dout_valid_o = r_doutValid;
  assign bus.dout_o       = r_dout;
  assign bus.done_o       = w_take;

endmodule
